ili9341_spi_sink: RTL and testbench
===================================

// Module: ili9341_spi_sink
// PURPOSE
//  Receive side of the ILI9341 4-wire SPI link (CS, SCK, MOSI, D/C) driven by the display controller.
//  Deserialises bytes and decodes CASET/PASET/RAMWR/SWRESET/SLPOUT/DISPON.
//  Writes received RGB565 pixels into a frame-buffer port at window-derived addresses.
//  Serves as an on-chip loopback/display model for checking frames end to end.
// PARAMETERS
//  WIDTH       240    columns; valid x = 0..WIDTH-1
//  HEIGHT      320    rows; valid y = 0..HEIGHT-1
//  PIXEL_SIZE  16     bits per pixel; must be 16 (RGB565, two bytes, MSB byte first)
//  ADDR_W      $clog2(WIDTH*HEIGHT)  frame-buffer address width
// PORTS
//  clk_out    in   1           system clock; SCK frequency must be <= clk_out/4
//  rst        in   1           reset, synchronous, active-low
//  spi_sck    in   1           serial clock, mode 0, idle low
//  spi_mosi   in   1           serial data, MSB first, sampled on SCK rising edge
//  spi_cs     in   1           chip select, active-low
//  spi_dc     in   1           0 = command byte, 1 = parameter/data byte
//  pix_we     out  1           one-cycle frame-buffer write strobe
//  pix_addr   out  ADDR_W      y*WIDTH + x of the written pixel
//  pix_data   out  PIXEL_SIZE  pixel value {hi_byte, lo_byte}
//  cmd_valid  out  1           one-cycle pulse per received command byte
//  cmd_byte   out  8           last received command byte
//  frame_done out  1           one-cycle pulse when last pixel of the window is written
//  disp_on    out  1           1 after DISPON (0x29), 0 after DISPOFF (0x28)/SWRESET
// BEHAVIOUR
//  - Inputs pass 2-FF synchronisers; SCK rising edge detected on synchronised copy.
//  - Bit counter 0..7; byte completes on 8th rising edge; D/C captured with the 8th bit.
//  - CS high: bit counter and pixel half-byte phase cleared immediately; partial byte discarded;
//    FSM state, window registers, and x/y counters retained.
//  - Latency: pix_we / cmd_valid assert exactly 4 clk_out cycles after the SCK rising edge of the last bit.
//  - Reset values: all outputs 0; cmd_byte 0x00; window SC=0, EC=WIDTH-1, SP=0, EP=HEIGHT-1;
//    x=SC, y=SP; FSM IDLE.
//  - FSM: IDLE, PARAM, RAM_HI, RAM_LO.
//    - Any command byte (dc=0), from any state, pulses cmd_valid and re-decodes.
//      0x2A/0x2B -> PARAM with idx=0.
//      0x2C -> RAM_HI with x=SC, y=SP.
//      0x01 -> window and disp_on reset to defaults, then IDLE.
//      0x28/0x29 -> disp_on update, then IDLE.
//      Anything else -> IDLE.
//    - PARAM: data bytes fill start_hi, start_lo, end_hi, end_lo (idx 0..3).
//      Target window register pair loads only on idx 3; FSM then returns to IDLE.
//      A command before idx 3 discards the partial parameters.
//    - RAM_HI: data byte latched as hi -> RAM_LO.
//    - RAM_LO: data byte forms the pixel; write issued; then RAM_HI.
//    - Data bytes in IDLE are ignored.
//  - Window rule: if end < start, the window degenerates to a single column/row equal to start.
//  - Advance after each pixel:
//    - x==EC: x=SC, y++.
//    - Additionally y==EP: frame_done pulses in the same cycle as pix_we; y=SP (wrap, stream continues).
//  - Out-of-range pixel (x>=WIDTH or y>=HEIGHT): pix_we suppressed, counters still advance,
//    frame_done still fires.
// CONFIGURATION
//  ILI9341_SINK_CHECKSUM_EN defined:
//    - Adds output frame_sum[15:0] (reset 0).
//    - Modulo-2^16 sum of all pixel values received since the last frame_done or RAMWR.
//    - Out-of-range pixels are included in the sum.
//    - Latched into frame_sum in the frame_done cycle; accumulator restarts at 0.
//  Undefined: no frame_sum port and no accumulator logic.
// TESTING
//  1 Reset: hold rst=0 3 cycles with SCK toggling -> all outputs 0, no pix_we/cmd_valid.
//  2 Full frame: RAMWR + 76800 pixels of 0xFFE0 -> 76800 pix_we, addr 0..76799,
//    data 0xFFE0, single frame_done on last.
//  3 Window: CASET 10..11, PASET 5..6, RAMWR, 4 px 0xF800
//    -> addrs 1210, 1211, 1450, 1451 and frame_done on the 4th;
//    a 5th px -> addr 1210.
//  4 CS abort: CS high after 5 bits of a pixel hi byte, then full pixel 0x07FF
//    -> written 0x07FF at the expected next address.
//  5 Truncated CASET (2 params) then RAMWR -> window unchanged; first pixel at addr 0;
//    cmd_valid count = 2.
//  6 Out of range: CASET 238..241, PASET 0..0, 4 px -> pix_we only for x=238,239;
//    frame_done on 4th; with ILI9341_SINK_CHECKSUM_EN, pixels 1,2,3,4 -> frame_sum = 10.

Source files
------------

// File: rtl/ili9341_spi_sink.sv
// ili9341_spi_sink
// Receive side of an ILI9341 4-wire SPI link (CS, SCK, MOSI, D/C).
// Deserialises bytes, decodes CASET/PASET/RAMWR/SWRESET/DISPON/DISPOFF and
// writes RGB565 pixels into a frame-buffer port at window-derived addresses.
// Optional feature macro: ILI9341_SINK_CHECKSUM_EN adds a per-frame
// modulo-2^16 pixel checksum output (frame_sum).
// SCK must run at no more than clk_out/4.
module ili9341_spi_sink #(
  parameter int WIDTH      = 240,
  parameter int HEIGHT     = 320,
  parameter int PIXEL_SIZE = 16,
  parameter int ADDR_W     = $clog2(WIDTH * HEIGHT)
) (
  input  logic                  clk_out,
  input  logic                  rst,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  input  logic                  spi_cs,
  input  logic                  spi_dc,
  output logic                  pix_we,
  output logic [ADDR_W-1:0]     pix_addr,
  output logic [PIXEL_SIZE-1:0] pix_data,
  output logic                  cmd_valid,
  output logic [7:0]            cmd_byte,
  output logic                  frame_done,
  output logic                  disp_on
`ifdef ILI9341_SINK_CHECKSUM_EN
  ,
  output logic [15:0]           frame_sum
`endif
);

  localparam int          XW     = $clog2(WIDTH);
  localparam int          YW     = $clog2(HEIGHT);
  localparam logic [15:0] EC_DEF = 16'(WIDTH - 1);
  localparam logic [15:0] EP_DEF = 16'(HEIGHT - 1);
  localparam logic [15:0] W_LIM  = 16'(WIDTH);
  localparam logic [15:0] H_LIM  = 16'(HEIGHT);

  typedef enum logic [1:0] {S_IDLE, S_PARAM, S_RAM_HI, S_RAM_LO} state_t;

  // synchronisers and deserialiser
  logic r_sck_s1, r_sck_s2, r_sck_d;
  logic r_mosi_s1, r_mosi_s2, r_cs_s1, r_cs_s2, r_dc_s1, r_dc_s2;
  logic [6:0] r_shift;
  logic [2:0] r_bitcnt;
  logic       r_byte_vld, r_byte_dc;
  logic [7:0] r_byte;
  logic       w_sck_rise;

  // control / datapath state and its next values
  state_t      r_state, w_state_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic        r_tgt_row, w_tgt_row_nxt;
  logic [7:0]  r_p0, r_p1, r_p2, r_hi, w_p0_nxt, w_p1_nxt, w_p2_nxt, w_hi_nxt;
  logic [15:0] r_sc, r_ec, r_sp, r_ep, w_sc_nxt, w_ec_nxt, w_sp_nxt, w_ep_nxt;
  logic [15:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic                  r_pix_we, w_pix_we_nxt, r_cmd_valid, w_cmd_valid_nxt;
  logic                  r_frame_done, w_frame_done_nxt, r_disp_on, w_disp_on_nxt;
  logic [ADDR_W-1:0]     r_pix_addr, w_pix_addr_nxt;
  logic [PIXEL_SIZE-1:0] r_pix_data, w_pix_data_nxt;
  logic [7:0]            r_cmd_byte, w_cmd_byte_nxt;
`ifdef ILI9341_SINK_CHECKSUM_EN
  logic [15:0] r_acc, w_acc_nxt, r_frame_sum, w_frame_sum_nxt;
`endif

  logic [PIXEL_SIZE-1:0] w_pixel;
  logic [15:0]           w_p_start, w_p_end, w_p_end_eff;
  logic                  w_in_range;
  logic [ADDR_W-1:0]     w_addr;

  assign w_sck_rise  = r_sck_s2 & ~r_sck_d;
  assign w_pixel     = {r_hi, r_byte};
  assign w_p_start   = {r_p0, r_p1};
  assign w_p_end     = {r_p2, r_byte};
  // A reversed window collapses to a single column/row at its start
  assign w_p_end_eff = (w_p_end < w_p_start) ? w_p_start : w_p_end;
  assign w_in_range  = (r_x < W_LIM) && (r_y < H_LIM);
  assign w_addr      = ADDR_W'(r_y[YW-1:0]) * ADDR_W'(WIDTH) + ADDR_W'(r_x[XW-1:0]);

  // Two-flop synchronisers on all SPI pins plus one SCK history flop for edge detection
  always_ff @(posedge clk_out) begin
    if (!rst) begin
      {r_sck_s1, r_sck_s2, r_sck_d}   <= 3'b000;
      {r_mosi_s1, r_mosi_s2}          <= 2'b00;
      {r_cs_s1, r_cs_s2}              <= 2'b11;
      {r_dc_s1, r_dc_s2}              <= 2'b00;
    end else begin
      {r_sck_s1, r_sck_s2, r_sck_d}   <= {spi_sck, r_sck_s1, r_sck_s2};
      {r_mosi_s1, r_mosi_s2}          <= {spi_mosi, r_mosi_s1};
      {r_cs_s1, r_cs_s2}              <= {spi_cs, r_cs_s1};
      {r_dc_s1, r_dc_s2}              <= {spi_dc, r_dc_s1};
    end
  end

  // Shift MOSI in on each SCK rise; on the 8th bit publish the byte with its D/C level
  always_ff @(posedge clk_out) begin
    if (!rst) begin
      r_shift    <= 7'd0;
      r_bitcnt   <= 3'd0;
      r_byte_vld <= 1'b0;
      r_byte_dc  <= 1'b0;
      r_byte     <= 8'd0;
    end else begin
      r_byte_vld <= 1'b0;
      if (r_cs_s2) begin
        r_bitcnt <= 3'd0;
      end else if (w_sck_rise) begin
        r_shift  <= {r_shift[5:0], r_mosi_s2};
        r_bitcnt <= r_bitcnt + 3'd1;
        if (r_bitcnt == 3'd7) begin
          r_byte_vld <= 1'b1;
          r_byte     <= {r_shift, r_mosi_s2};
          r_byte_dc  <= r_dc_s2;
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_out) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command decode, parameter collection, pixel assembly and window cursor advance
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_tgt_row_nxt    = r_tgt_row;
    w_p0_nxt         = r_p0;
    w_p1_nxt         = r_p1;
    w_p2_nxt         = r_p2;
    w_hi_nxt         = r_hi;
    w_sc_nxt         = r_sc;
    w_ec_nxt         = r_ec;
    w_sp_nxt         = r_sp;
    w_ep_nxt         = r_ep;
    w_x_nxt          = r_x;
    w_y_nxt          = r_y;
    w_pix_we_nxt     = 1'b0;
    w_pix_addr_nxt   = r_pix_addr;
    w_pix_data_nxt   = r_pix_data;
    w_cmd_valid_nxt  = 1'b0;
    w_cmd_byte_nxt   = r_cmd_byte;
    w_frame_done_nxt = 1'b0;
    w_disp_on_nxt    = r_disp_on;
`ifdef ILI9341_SINK_CHECKSUM_EN
    w_acc_nxt        = r_acc;
    w_frame_sum_nxt  = r_frame_sum;
`endif
    if (r_byte_vld && !r_byte_dc) begin
      w_cmd_valid_nxt = 1'b1;
      w_cmd_byte_nxt  = r_byte;
      case (r_byte)
        8'h2A: begin w_state_nxt = S_PARAM; w_idx_nxt = 2'd0; w_tgt_row_nxt = 1'b0; end
        8'h2B: begin w_state_nxt = S_PARAM; w_idx_nxt = 2'd0; w_tgt_row_nxt = 1'b1; end
        8'h2C: begin
          w_state_nxt = S_RAM_HI;
          w_x_nxt     = r_sc;
          w_y_nxt     = r_sp;
`ifdef ILI9341_SINK_CHECKSUM_EN
          w_acc_nxt   = 16'd0;
`endif
        end
        8'h01: begin
          w_sc_nxt      = 16'd0;
          w_ec_nxt      = EC_DEF;
          w_sp_nxt      = 16'd0;
          w_ep_nxt      = EP_DEF;
          w_disp_on_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end
        8'h28:   begin w_disp_on_nxt = 1'b0; w_state_nxt = S_IDLE; end
        8'h29:   begin w_disp_on_nxt = 1'b1; w_state_nxt = S_IDLE; end
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (r_byte_vld) begin
      case (r_state)
        S_PARAM: begin
          case (r_idx)
            2'd0:    begin w_p0_nxt = r_byte; w_idx_nxt = 2'd1; end
            2'd1:    begin w_p1_nxt = r_byte; w_idx_nxt = 2'd2; end
            2'd2:    begin w_p2_nxt = r_byte; w_idx_nxt = 2'd3; end
            default: begin
              if (r_tgt_row) begin
                w_sp_nxt = w_p_start;
                w_ep_nxt = w_p_end_eff;
              end else begin
                w_sc_nxt = w_p_start;
                w_ec_nxt = w_p_end_eff;
              end
              w_idx_nxt   = 2'd0;
              w_state_nxt = S_IDLE;
            end
          endcase
        end
        S_RAM_HI: begin
          w_hi_nxt    = r_byte;
          w_state_nxt = S_RAM_LO;
        end
        S_RAM_LO: begin
          if (w_in_range) begin
            w_pix_we_nxt   = 1'b1;
            w_pix_addr_nxt = w_addr;
            w_pix_data_nxt = w_pixel;
          end else begin
            w_pix_we_nxt   = 1'b0;
          end
`ifdef ILI9341_SINK_CHECKSUM_EN
          w_acc_nxt = r_acc + w_pixel;
`endif
          if (r_x >= r_ec) begin
            w_x_nxt = r_sc;
            if (r_y >= r_ep) begin
              w_y_nxt          = r_sp;
              w_frame_done_nxt = 1'b1;
`ifdef ILI9341_SINK_CHECKSUM_EN
              w_frame_sum_nxt  = r_acc + w_pixel;
              w_acc_nxt        = 16'd0;
`endif
            end else begin
              w_y_nxt = r_y + 16'd1;
            end
          end else begin
            w_x_nxt = r_x + 16'd1;
          end
          w_state_nxt = S_RAM_HI;
        end
        default: w_state_nxt = r_state;
      endcase
    end else if (r_cs_s2 && (r_state == S_RAM_LO)) begin
      // Deselect drops a half-received pixel; the stream resumes on a high byte
      w_state_nxt = S_RAM_HI;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_out) begin
    if (!rst) begin
      r_idx <= 2'd0;  r_tgt_row <= 1'b0;
      r_p0  <= 8'd0;  r_p1 <= 8'd0;  r_p2 <= 8'd0;  r_hi <= 8'd0;
      r_sc  <= 16'd0; r_ec <= EC_DEF; r_sp <= 16'd0; r_ep <= EP_DEF;
      r_x   <= 16'd0; r_y  <= 16'd0;
      r_pix_we <= 1'b0; r_pix_addr <= '0; r_pix_data <= '0;
      r_cmd_valid <= 1'b0; r_cmd_byte <= 8'd0;
      r_frame_done <= 1'b0; r_disp_on <= 1'b0;
`ifdef ILI9341_SINK_CHECKSUM_EN
      r_acc <= 16'd0; r_frame_sum <= 16'd0;
`endif
    end else begin
      r_idx <= w_idx_nxt;  r_tgt_row <= w_tgt_row_nxt;
      r_p0  <= w_p0_nxt;   r_p1 <= w_p1_nxt;  r_p2 <= w_p2_nxt;  r_hi <= w_hi_nxt;
      r_sc  <= w_sc_nxt;   r_ec <= w_ec_nxt;  r_sp <= w_sp_nxt;  r_ep <= w_ep_nxt;
      r_x   <= w_x_nxt;    r_y  <= w_y_nxt;
      r_pix_we <= w_pix_we_nxt; r_pix_addr <= w_pix_addr_nxt; r_pix_data <= w_pix_data_nxt;
      r_cmd_valid <= w_cmd_valid_nxt; r_cmd_byte <= w_cmd_byte_nxt;
      r_frame_done <= w_frame_done_nxt; r_disp_on <= w_disp_on_nxt;
`ifdef ILI9341_SINK_CHECKSUM_EN
      r_acc <= w_acc_nxt; r_frame_sum <= w_frame_sum_nxt;
`endif
    end
  end

  assign pix_we     = r_pix_we;
  assign pix_addr   = r_pix_addr;
  assign pix_data   = r_pix_data;
  assign cmd_valid  = r_cmd_valid;
  assign cmd_byte   = r_cmd_byte;
  assign frame_done = r_frame_done;
  assign disp_on    = r_disp_on;
`ifdef ILI9341_SINK_CHECKSUM_EN
  assign frame_sum  = r_frame_sum;
`endif

endmodule

// File: tb/tb_ili9341_spi_sink.sv
// Self-checking bench for ili9341_spi_sink: directed scenarios plus
// randomised windows/pixel streams, checked against a byte-level model.
module tb_ili9341_spi_sink;
  localparam int W = 240;
  localparam int H = 320;

  logic clk_out = 1'b0, rst = 1'b0;
  logic spi_sck = 1'b0, spi_mosi = 1'b0, spi_cs = 1'b1, spi_dc = 1'b0;
  logic        pix_we, cmd_valid, frame_done, disp_on;
  logic [16:0] pix_addr;
  logic [15:0] pix_data;
  logic [7:0]  cmd_byte;
`ifdef ILI9341_SINK_CHECKSUM_EN
  logic [15:0] frame_sum;
`endif

  ili9341_spi_sink dut (
    .clk_out(clk_out), .rst(rst), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_cs(spi_cs), .spi_dc(spi_dc), .pix_we(pix_we), .pix_addr(pix_addr),
    .pix_data(pix_data), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .frame_done(frame_done), .disp_on(disp_on)
`ifdef ILI9341_SINK_CHECKSUM_EN
    , .frame_sum(frame_sum)
`endif
  );

  always #5 clk_out = ~clk_out;

  typedef struct { logic we; int addr; int data; logic fd; } ev_t;
  ev_t got_q[$];
  ev_t exp_q[$];
  int  n_checks = 0, n_fail = 0;
  int  cyc = 0, last_rise = -100, got_cmds = 0;

  // reference model state
  int m_sc, m_ec, m_sp, m_ep, m_x, m_y, m_mode, m_hi, m_disp, m_sum, m_fsum;
  int m_cmds, m_last_cmd;
  bit m_half;
  int m_par[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  always @(posedge clk_out) cyc <= cyc + 1;

  // Collect DUT events and check output latency relative to the last SCK rise
  always @(negedge clk_out) begin
    if (rst) begin
      if (pix_we || frame_done) got_q.push_back('{pix_we, int'(pix_addr), int'(pix_data), frame_done});
      if (cmd_valid) got_cmds++;
      if (pix_we || cmd_valid) chk("latency", 32'(cyc - last_rise), 32'd4);
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_sc = 0; m_ec = W - 1; m_sp = 0; m_ep = H - 1; m_x = 0; m_y = 0;
    m_mode = 0; m_half = 0; m_disp = 0; m_sum = 0; m_fsum = 0; m_cmds = 0; m_last_cmd = 0;
  endtask

  task automatic model_cmd(input int b);
    m_cmds++; m_last_cmd = b; m_half = 0;
    case (b)
      'h2A: begin m_mode = 1; m_par.delete(); end
      'h2B: begin m_mode = 2; m_par.delete(); end
      'h2C: begin m_mode = 3; m_x = m_sc; m_y = m_sp; m_sum = 0; end
      'h01: begin m_sc = 0; m_ec = W - 1; m_sp = 0; m_ep = H - 1; m_disp = 0; m_mode = 0; end
      'h28: begin m_disp = 0; m_mode = 0; end
      'h29: begin m_disp = 1; m_mode = 0; end
      default: m_mode = 0;
    endcase
  endtask

  task automatic model_data(input int b);
    int s, e, p;
    bit inr, last;
    if (m_mode == 1 || m_mode == 2) begin
      m_par.push_back(b);
      if (m_par.size() == 4) begin
        s = m_par[0] * 256 + m_par[1];
        e = m_par[2] * 256 + m_par[3];
        if (e < s) e = s;
        if (m_mode == 1) begin m_sc = s; m_ec = e; end
        else begin m_sp = s; m_ep = e; end
        m_mode = 0;
      end
    end else if (m_mode == 3) begin
      if (!m_half) begin
        m_hi = b; m_half = 1;
      end else begin
        m_half = 0;
        p = m_hi * 256 + b;
        m_sum = (m_sum + p) % 65536;
        inr  = (m_x < W) && (m_y < H);
        last = (m_x == m_ec) && (m_y == m_ep);
        if (inr || last) exp_q.push_back('{inr, inr ? m_y * W + m_x : 0, p, last});
        if (last) begin m_fsum = m_sum; m_sum = 0; end
        if (m_x == m_ec) begin
          m_x = m_sc;
          if (m_y == m_ep) m_y = m_sp; else m_y++;
        end else m_x++;
      end
    end
  endtask

  task automatic spi_bit(input logic b, input bit last);
    @(negedge clk_out); spi_sck = 1'b0; spi_mosi = b;
    @(negedge clk_out);
    @(negedge clk_out); spi_sck = 1'b1; if (last) last_rise = cyc;
    @(negedge clk_out);
  endtask

  task automatic spi_byte(input logic dc, input logic [7:0] b);
    spi_cs = 1'b0; spi_dc = dc;
    for (int i = 7; i >= 0; i--) spi_bit(b[i], i == 0);
    @(negedge clk_out); spi_sck = 1'b0;
  endtask

  task automatic spi_abort(input int nbits);
    spi_cs = 1'b0;
    for (int i = 0; i < nbits; i++) spi_bit(1'($urandom_range(0, 1)), 1'b0);
    @(negedge clk_out); spi_sck = 1'b0; spi_cs = 1'b1;
    repeat (4) @(negedge clk_out);
    spi_cs = 1'b0;
    repeat (2) @(negedge clk_out);
    if (m_mode == 3) m_half = 0;
  endtask

  task automatic send_cmd(input int b);  model_cmd(b);  spi_byte(1'b0, 8'(b)); endtask
  task automatic send_data(input int b); model_data(b); spi_byte(1'b1, 8'(b)); endtask
  task automatic send_params(input int s, input int e);
    send_data(s / 256); send_data(s % 256); send_data(e / 256); send_data(e % 256);
  endtask
  task automatic send_pixel(input int p, input bit abort_mid);
    send_data(p / 256);
    if (abort_mid) spi_abort($urandom_range(1, 7));
    send_data(p % 256);
  endtask

  task automatic settle(); repeat (10) @(negedge clk_out); endtask

  task automatic check_scn(input string tag);
    int n;
    chk({tag, ".nev"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.we%0d", tag, i), 32'(got_q[i].we), 32'(exp_q[i].we));
      chk($sformatf("%s.fd%0d", tag, i), 32'(got_q[i].fd), 32'(exp_q[i].fd));
      if (exp_q[i].we) begin
        chk($sformatf("%s.addr%0d", tag, i), 32'(got_q[i].addr), 32'(exp_q[i].addr));
        chk($sformatf("%s.data%0d", tag, i), 32'(got_q[i].data), 32'(exp_q[i].data));
      end
    end
    chk({tag, ".ncmd"}, 32'(got_cmds), 32'(m_cmds));
    chk({tag, ".cmdbyte"}, 32'(cmd_byte), 32'(m_last_cmd));
    chk({tag, ".disp"}, 32'(disp_on), 32'(m_disp));
`ifdef ILI9341_SINK_CHECKSUM_EN
    chk({tag, ".fsum"}, 32'(frame_sum), 32'(m_fsum));
`endif
    got_q.delete(); exp_q.delete(); got_cmds = 0; m_cmds = 0;
  endtask

  initial begin
    int s0, e0, s1, e1, npx;
    model_reset();
    // reset held with SCK toggling
    repeat (6) begin @(negedge clk_out); spi_sck = ~spi_sck; end
    chk("rst.we", 32'(pix_we), 32'd0);       chk("rst.cmdv", 32'(cmd_valid), 32'd0);
    chk("rst.fd", 32'(frame_done), 32'd0);   chk("rst.disp", 32'(disp_on), 32'd0);
    chk("rst.cmdb", 32'(cmd_byte), 32'd0);   chk("rst.addr", 32'(pix_addr), 32'd0);
    chk("rst.data", 32'(pix_data), 32'd0);
    @(negedge clk_out); spi_sck = 1'b0; rst = 1'b1;
    settle();
    check_scn("rst");

    // window CASET 10..11, PASET 5..6, four red pixels
    send_cmd('h2A); send_params(10, 11);
    send_cmd('h2B); send_params(5, 6);
    send_cmd('h2C);
    repeat (4) send_pixel('hF800, 1'b0);
    settle();
    if (got_q.size() == 4) begin
      chk("win.a0", 32'(got_q[0].addr), 32'd1210); chk("win.a1", 32'(got_q[1].addr), 32'd1211);
      chk("win.a2", 32'(got_q[2].addr), 32'd1450); chk("win.a3", 32'(got_q[3].addr), 32'd1451);
      chk("win.fd3", 32'(got_q[3].fd), 32'd1);     chk("win.d0", 32'(got_q[0].data), 32'hF800);
    end else chk("win.size", 32'(got_q.size()), 32'd4);
    check_scn("win");
    send_pixel('hF800, 1'b0); settle();
    if (got_q.size() == 1) chk("win5.a", 32'(got_q[0].addr), 32'd1210);
    else chk("win5.size", 32'(got_q.size()), 32'd1);
    check_scn("win5");

    // CS abort in the middle of a high byte
    spi_abort(5); send_pixel('h07FF, 1'b0); settle();
    if (got_q.size() == 1) begin
      chk("abort.a", 32'(got_q[0].addr), 32'd1211); chk("abort.d", 32'(got_q[0].data), 32'h07FF);
    end else chk("abort.size", 32'(got_q.size()), 32'd1);
    check_scn("abort");

    // truncated CASET leaves the default window in place
    send_cmd('h01); send_cmd('h2A); send_data(0); send_data(5);
    send_cmd('h2C); send_pixel('h1234, 1'b0); settle();
    if (got_q.size() == 1) chk("trunc.a", 32'(got_q[0].addr), 32'd0);
    else chk("trunc.size", 32'(got_q.size()), 32'd1);
    check_scn("trunc");

    // out-of-range columns 240/241 suppressed, frame_done still fires
    send_cmd('h2A); send_params(238, 241);
    send_cmd('h2B); send_params(0, 0);
    send_cmd('h2C);
    for (int i = 1; i <= 4; i++) send_pixel(i, 1'b0);
    settle();
    chk("oor.nev", 32'(got_q.size()), 32'd3);
`ifdef ILI9341_SINK_CHECKSUM_EN
    chk("oor.sum", 32'(frame_sum), 32'd10);
`endif
    check_scn("oor");

    // bottom-right corner of the panel
    send_cmd('h2A); send_params(238, 239);
    send_cmd('h2B); send_params(318, 319);
    send_cmd('h2C);
    repeat (4) send_pixel('hFFE0, 1'b0);
    settle();
    if (got_q.size() == 4) chk("corner.a3", 32'(got_q[3].addr), 32'd76799);
    else chk("corner.size", 32'(got_q.size()), 32'd4);
    check_scn("corner");

    // display on/off, data ignored in IDLE, SWRESET clears disp_on
    send_cmd('h29); send_data('h55); settle(); check_scn("dispon");
    send_cmd('h28); settle(); check_scn("dispoff");
    send_cmd('h29); send_cmd('h01); settle(); check_scn("swreset");

    // randomised windows, streams, aborts and interleaved commands
    for (int it = 0; it < 12; it++) begin
      s0 = $urandom_range(0, 243);
      e0 = ($urandom_range(0, 4) == 0 && s0 >= 3) ? s0 - $urandom_range(1, 3) : s0 + $urandom_range(0, 3);
      s1 = $urandom_range(0, 323);
      e1 = ($urandom_range(0, 4) == 0 && s1 >= 2) ? s1 - 2 : s1 + $urandom_range(0, 2);
      send_cmd('h2A); send_params(s0, e0);
      send_cmd('h2B); send_params(s1, e1);
      if ($urandom_range(0, 3) == 0) send_data($urandom_range(0, 255));
      send_cmd('h2C);
      npx = (m_ec - m_sc + 1) * (m_ep - m_sp + 1) + $urandom_range(0, 3);
      for (int k = 0; k < npx; k++) begin
        if ($urandom_range(0, 7) == 0) spi_abort($urandom_range(1, 7));
        send_pixel($urandom_range(0, 65535), $urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 1) == 0) send_cmd($urandom_range(0, 1) == 0 ? 'h29 : 'h28);
      settle();
      check_scn($sformatf("rnd%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
